// File: rtl/mc_ctrl_ext.sv
// -----------------------------------------------------------------------------
// mc_ctrl_ext
//
// Multicycle MIPS control unit. It is a Moore FSM with op/funct decode that
// steers the PC, IR, register file, ALU and unified memory of the multicycle
// datapath. On top of the base controller it provides:
//   - optional memory wait states via mem_ready (FETCH, MEMRD, MEMWR),
//   - optional extended opcodes ANDI, ORI, SLTI, BNE and JAL,
//   - internal PC-enable generation (fetch/jump or taken branch),
//   - a one-cycle illegal-instruction pulse from DECODE,
//   - a wrapping retired-instruction counter.
//
// Parameters
//   MEM_WAIT   1 = honour mem_ready, 0 = treat mem_ready as always 1
//   EXT_OPS    1 = ANDI/ORI/SLTI/BNE/JAL legal, 0 = they decode as illegal
//   CNT_W      width of the retired counter
//
// Ports
//   clk, reset           clock (rising edge), asynchronous active-high reset
//   op, funct            IR[31:26], IR[5:0]
//   zero                 ALU zero flag
//   mem_ready            memory access completes this cycle
//   pcen                 PC load enable
//   irwrite/memwrite/regwrite  datapath write enables
//   iord                 0 = PC addresses memory, 1 = ALUOut
//   alusrca              0 = PC, 1 = A
//   alusrcb              00 = B, 01 = 4, 10 = immext, 11 = signimm<<2
//   zeroext              1 = zero-extend immediate
//   regdst               00 = rt, 01 = rd, 10 = r31
//   memtoreg             00 = ALUOut, 01 = mem data, 10 = PC
//   pcsrc                00 = ALU result, 01 = ALUOut, 10 = jump target
//   alucontrol           010 add, 110 sub, 000 and, 001 or, 111 slt
//   illegal              unsupported op/funct decoded (one-cycle pulse)
//   retired              completed instruction count
// -----------------------------------------------------------------------------
module mc_ctrl_ext #(
    parameter int MEM_WAIT = 1,
    parameter int EXT_OPS  = 1,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pcen,
    output logic             irwrite,
    output logic             memwrite,
    output logic             regwrite,
    output logic             iord,
    output logic             alusrca,
    output logic [1:0]       alusrcb,
    output logic             zeroext,
    output logic [1:0]       regdst,
    output logic [1:0]       memtoreg,
    output logic [1:0]       pcsrc,
    output logic [2:0]       alucontrol,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    localparam logic [3:0] S_FETCH   = 4'd0;
    localparam logic [3:0] S_DECODE  = 4'd1;
    localparam logic [3:0] S_MEMADR  = 4'd2;
    localparam logic [3:0] S_MEMRD   = 4'd3;
    localparam logic [3:0] S_MEMWB   = 4'd4;
    localparam logic [3:0] S_MEMWR   = 4'd5;
    localparam logic [3:0] S_RTYPEEX = 4'd6;
    localparam logic [3:0] S_RTYPEWB = 4'd7;
    localparam logic [3:0] S_BREX    = 4'd8;
    localparam logic [3:0] S_IMMEX   = 4'd9;
    localparam logic [3:0] S_IMMWB   = 4'd10;
    localparam logic [3:0] S_JEX     = 4'd11;
    localparam logic [3:0] S_JALEX   = 4'd12;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam bit WAIT_EN = (MEM_WAIT != 0);
    localparam bit EXT_EN  = (EXT_OPS != 0);

    logic [3:0]       state_q, state_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    logic rdy;
    logic retireEvt;
    logic pcenRaw, irwriteRaw, memwriteRaw, regwriteRaw, illegalRaw;

    logic isLw, isSw, isRtype, isBeq, isBne, isAddi, isAndi, isOri, isSlti, isJ, isJal;
    logic functLegal;
    logic [2:0] rtypeAlu;

    // Opcode decode; extended opcodes only count as recognised when enabled,
    // so with EXT_OPS=0 they simply fall through to the illegal path.
    assign isLw    = (op == OP_LW);
    assign isSw    = (op == OP_SW);
    assign isRtype = (op == OP_RTYPE);
    assign isBeq   = (op == OP_BEQ);
    assign isBne   = (op == OP_BNE)  && EXT_EN;
    assign isAddi  = (op == OP_ADDI);
    assign isAndi  = (op == OP_ANDI) && EXT_EN;
    assign isOri   = (op == OP_ORI)  && EXT_EN;
    assign isSlti  = (op == OP_SLTI) && EXT_EN;
    assign isJ     = (op == OP_J);
    assign isJal   = (op == OP_JAL)  && EXT_EN;

    // With wait states disabled the memory is treated as always ready.
    assign rdy = mem_ready | ~WAIT_EN;

    // R-type funct decode: legality flag plus the ALU operation to use.
    always_comb begin
        functLegal = 1'b1;
        rtypeAlu   = ALU_ADD;
        case (funct)
            6'h20:   rtypeAlu = ALU_ADD;
            6'h22:   rtypeAlu = ALU_SUB;
            6'h24:   rtypeAlu = ALU_AND;
            6'h25:   rtypeAlu = ALU_OR;
            6'h2A:   rtypeAlu = ALU_SLT;
            default: functLegal = 1'b0;
        endcase
    end

    // Next-state and output decode. Everything defaults to 0 with the ALU on
    // add; unused state codes 13-15 fall into the default branch and return
    // to FETCH with no enables. retireEvt marks transitions into FETCH that
    // complete an instruction.
    always_comb begin
        state_d     = S_FETCH;
        retireEvt   = 1'b0;
        pcenRaw     = 1'b0;
        irwriteRaw  = 1'b0;
        memwriteRaw = 1'b0;
        regwriteRaw = 1'b0;
        illegalRaw  = 1'b0;
        iord        = 1'b0;
        alusrca     = 1'b0;
        alusrcb     = 2'b00;
        zeroext     = 1'b0;
        regdst      = 2'b00;
        memtoreg    = 2'b00;
        pcsrc       = 2'b00;
        alucontrol  = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                alusrcb    = 2'b01;
                irwriteRaw = rdy;
                pcenRaw    = rdy;
                state_d    = rdy ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                if (isLw || isSw) begin
                    state_d = S_MEMADR;
                end else if (isRtype && functLegal) begin
                    state_d = S_RTYPEEX;
                end else if (isBeq || isBne) begin
                    state_d = S_BREX;
                end else if (isAddi || isAndi || isOri || isSlti) begin
                    state_d = S_IMMEX;
                end else if (isJ) begin
                    state_d = S_JEX;
                end else if (isJal) begin
                    state_d = S_JALEX;
                end else begin
                    // PC was already advanced in FETCH, so dropping back acts as a NOP.
                    illegalRaw = 1'b1;
                    state_d    = S_FETCH;
                end
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = isLw ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                iord    = 1'b1;
                state_d = rdy ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                regwriteRaw = 1'b1;
                memtoreg    = 2'b01;
                retireEvt   = 1'b1;
            end
            S_MEMWR: begin
                // Address and data stay put while the write is held pending rdy.
                iord        = 1'b1;
                memwriteRaw = 1'b1;
                state_d     = rdy ? S_FETCH : S_MEMWR;
                retireEvt   = rdy;
            end
            S_RTYPEEX: begin
                alusrca    = 1'b1;
                alucontrol = rtypeAlu;
                state_d    = S_RTYPEWB;
            end
            S_RTYPEWB: begin
                regwriteRaw = 1'b1;
                regdst      = 2'b01;
                retireEvt   = 1'b1;
            end
            S_BREX: begin
                alusrca    = 1'b1;
                alucontrol = ALU_SUB;
                pcsrc      = 2'b01;
                pcenRaw    = isBne ? ~zero : zero;
                retireEvt  = 1'b1;
            end
            S_IMMEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = S_IMMWB;
                if (isAndi) begin
                    alucontrol = ALU_AND;
                    zeroext    = 1'b1;
                end else if (isOri) begin
                    alucontrol = ALU_OR;
                    zeroext    = 1'b1;
                end else if (isSlti) begin
                    alucontrol = ALU_SLT;
                end
            end
            S_IMMWB: begin
                regwriteRaw = 1'b1;
                retireEvt   = 1'b1;
            end
            S_JEX: begin
                pcsrc     = 2'b10;
                pcenRaw   = 1'b1;
                retireEvt = 1'b1;
            end
            S_JALEX: begin
                // Link register receives the already-incremented PC.
                pcsrc       = 2'b10;
                pcenRaw     = 1'b1;
                regwriteRaw = 1'b1;
                regdst      = 2'b10;
                memtoreg    = 2'b10;
                retireEvt   = 1'b1;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Retired counter wraps naturally at 2^CNT_W.
    always_comb begin
        retired_d = retired_q;
        if (retireEvt) begin
            retired_d = retired_q + CNT_W'(1);
        end
    end

    // State and counter registers; reset abandons any instruction in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    // Side-effecting strobes are blocked combinationally while reset is high,
    // so nothing is written even within the cycle reset arrives.
    assign pcen     = pcenRaw     & ~reset;
    assign irwrite  = irwriteRaw  & ~reset;
    assign memwrite = memwriteRaw & ~reset;
    assign regwrite = regwriteRaw & ~reset;
    assign illegal  = illegalRaw  & ~reset;
    assign retired  = retired_q;

endmodule

// File: tb/tb_mc_ctrl_ext.sv
// -----------------------------------------------------------------------------
// tb_mc_ctrl_ext
//
// Scoreboard bench for mc_ctrl_ext. Instance A uses MEM_WAIT=1, EXT_OPS=1 and
// a 4-bit counter so wraparound is reachable; instance B uses EXT_OPS=0 and
// shares A's inputs. Each stimulus cycle pushes hand-computed expected outputs
// into a queue; a monitor on the falling edge pops and compares them.
// -----------------------------------------------------------------------------
module tb_mc_ctrl_ext;

    typedef struct packed {
        logic       pcen;
        logic       irwrite;
        logic       memwrite;
        logic       regwrite;
        logic       iord;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic       zeroext;
        logic [1:0] regdst;
        logic [1:0] memtoreg;
        logic [1:0] pcsrc;
        logic [2:0] alucontrol;
        logic       illegal;
    } ctrl_t;

    typedef struct {
        ctrl_t       expA;
        logic [3:0]  retA;
        logic        chkB;
        ctrl_t       expB;
        logic [31:0] retB;
    } exp_t;

    localparam logic [5:0] RT = 6'h00, J = 6'h02, JAL = 6'h03, BEQ = 6'h04, BNE = 6'h05;
    localparam logic [5:0] ADDI = 6'h08, SLTI = 6'h0A, ANDI = 6'h0C, ORI = 6'h0D;
    localparam logic [5:0] LW = 6'h23, SW = 6'h2B;

    // Expected control words for each state, written out by hand.
    localparam ctrl_t C_FW      = '{alusrcb:2'b01, alucontrol:3'b010, default:'0};
    localparam ctrl_t C_FR      = '{pcen:1'b1, irwrite:1'b1, alusrcb:2'b01, alucontrol:3'b010, default:'0};
    localparam ctrl_t C_DEC     = '{alusrcb:2'b11, alucontrol:3'b010, default:'0};
    localparam ctrl_t C_DEC_ILL = '{alusrcb:2'b11, alucontrol:3'b010, illegal:1'b1, default:'0};
    localparam ctrl_t C_MADR    = '{alusrca:1'b1, alusrcb:2'b10, alucontrol:3'b010, default:'0};
    localparam ctrl_t C_MRD     = '{iord:1'b1, alucontrol:3'b010, default:'0};
    localparam ctrl_t C_MWB     = '{regwrite:1'b1, memtoreg:2'b01, alucontrol:3'b010, default:'0};
    localparam ctrl_t C_MWR     = '{iord:1'b1, memwrite:1'b1, alucontrol:3'b010, default:'0};
    localparam ctrl_t C_REX_ADD = '{alusrca:1'b1, alucontrol:3'b010, default:'0};
    localparam ctrl_t C_REX_SUB = '{alusrca:1'b1, alucontrol:3'b110, default:'0};
    localparam ctrl_t C_REX_SLT = '{alusrca:1'b1, alucontrol:3'b111, default:'0};
    localparam ctrl_t C_RWB     = '{regwrite:1'b1, regdst:2'b01, alucontrol:3'b010, default:'0};
    localparam ctrl_t C_BR_T    = '{pcen:1'b1, alusrca:1'b1, pcsrc:2'b01, alucontrol:3'b110, default:'0};
    localparam ctrl_t C_BR_N    = '{alusrca:1'b1, pcsrc:2'b01, alucontrol:3'b110, default:'0};
    localparam ctrl_t C_IEX_ADD = '{alusrca:1'b1, alusrcb:2'b10, alucontrol:3'b010, default:'0};
    localparam ctrl_t C_IEX_AND = '{alusrca:1'b1, alusrcb:2'b10, zeroext:1'b1, alucontrol:3'b000, default:'0};
    localparam ctrl_t C_IEX_OR  = '{alusrca:1'b1, alusrcb:2'b10, zeroext:1'b1, alucontrol:3'b001, default:'0};
    localparam ctrl_t C_IEX_SLT = '{alusrca:1'b1, alusrcb:2'b10, alucontrol:3'b111, default:'0};
    localparam ctrl_t C_IWB     = '{regwrite:1'b1, alucontrol:3'b010, default:'0};
    localparam ctrl_t C_JEX     = '{pcen:1'b1, pcsrc:2'b10, alucontrol:3'b010, default:'0};
    localparam ctrl_t C_JAL     = '{pcen:1'b1, regwrite:1'b1, regdst:2'b10, memtoreg:2'b10, pcsrc:2'b10, alucontrol:3'b010, default:'0};

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op, funct;
    logic       zero, memReady;

    logic        pcenA, irwriteA, memwriteA, regwriteA, iordA, alusrcaA, zeroextA, illegalA;
    logic [1:0]  alusrcbA, regdstA, memtoregA, pcsrcA;
    logic [2:0]  alucontrolA;
    logic [3:0]  retiredA;
    logic        pcenB, irwriteB, memwriteB, regwriteB, iordB, alusrcaB, zeroextB, illegalB;
    logic [1:0]  alusrcbB, regdstB, memtoregB, pcsrcB;
    logic [2:0]  alucontrolB;
    logic [31:0] retiredB;
    ctrl_t       actA, actB;

    exp_t  expQ[$];
    string tagQ[$];
    int    checks = 0;
    int    errors = 0;

    always #5 clk = ~clk;

    mc_ctrl_ext #(.MEM_WAIT(1), .EXT_OPS(1), .CNT_W(4)) dutA (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(memReady),
        .pcen(pcenA), .irwrite(irwriteA), .memwrite(memwriteA), .regwrite(regwriteA),
        .iord(iordA), .alusrca(alusrcaA), .alusrcb(alusrcbA), .zeroext(zeroextA),
        .regdst(regdstA), .memtoreg(memtoregA), .pcsrc(pcsrcA), .alucontrol(alucontrolA),
        .illegal(illegalA), .retired(retiredA)
    );

    mc_ctrl_ext #(.MEM_WAIT(1), .EXT_OPS(0), .CNT_W(32)) dutB (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(memReady),
        .pcen(pcenB), .irwrite(irwriteB), .memwrite(memwriteB), .regwrite(regwriteB),
        .iord(iordB), .alusrca(alusrcaB), .alusrcb(alusrcbB), .zeroext(zeroextB),
        .regdst(regdstB), .memtoreg(memtoregB), .pcsrc(pcsrcB), .alucontrol(alucontrolB),
        .illegal(illegalB), .retired(retiredB)
    );

    assign actA = {pcenA, irwriteA, memwriteA, regwriteA, iordA, alusrcaA, alusrcbA, zeroextA,
                   regdstA, memtoregA, pcsrcA, alucontrolA, illegalA};
    assign actB = {pcenB, irwriteB, memwriteB, regwriteB, iordB, alusrcaB, alusrcbB, zeroextB,
                   regdstB, memtoregB, pcsrcB, alucontrolB, illegalB};

    // One comparison: counts it and reports a FAIL line on mismatch.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: compares every cycle that has a pending expectation.
    exp_t  monE;
    string monT;
    always @(negedge clk) begin
        if (expQ.size() != 0) begin
            monE = expQ.pop_front();
            monT = tagQ.pop_front();
            checkOutput({monT, " ctrlA"}, {11'b0, actA}, {11'b0, monE.expA});
            checkOutput({monT, " retiredA"}, {28'b0, retiredA}, {28'b0, monE.retA});
            if (monE.chkB) begin
                checkOutput({monT, " ctrlB"}, {11'b0, actB}, {11'b0, monE.expB});
                checkOutput({monT, " retiredB"}, retiredB, monE.retB);
            end
        end
    end

    // Drives one cycle of inputs, queues its expectation and steps to the next cycle.
    task automatic stepCore(input string tag, input logic [5:0] o, input logic [5:0] f,
                            input logic z, input logic r, input ctrl_t eA, input logic [3:0] rA,
                            input logic cb, input ctrl_t eB, input logic [31:0] rB);
        exp_t e;
        op       = o;
        funct    = f;
        zero     = z;
        memReady = r;
        e.expA = eA;
        e.retA = rA;
        e.chkB = cb;
        e.expB = eB;
        e.retB = rB;
        expQ.push_back(e);
        tagQ.push_back(tag);
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input string tag, input logic [5:0] o, input logic [5:0] f,
                                 input logic z, input logic r, input ctrl_t eA, input logic [3:0] rA);
        stepCore(tag, o, f, z, r, eA, rA, 1'b0, '0, 32'd0);
    endtask

    task automatic doRtype(input logic [5:0] f, input ctrl_t ex, input logic [3:0] ret);
        applyStimulus("rF", RT, f, 1'b0, 1'b1, C_FR, ret);
        applyStimulus("rD", RT, f, 1'b0, 1'b0, C_DEC, ret);
        applyStimulus("rEX", RT, f, 1'b0, 1'b0, ex, ret);
        applyStimulus("rWB", RT, f, 1'b0, 1'b0, C_RWB, ret);
    endtask

    task automatic doImm(input logic [5:0] o, input ctrl_t ex, input logic [3:0] ret);
        applyStimulus("iF", o, 6'h00, 1'b0, 1'b1, C_FR, ret);
        applyStimulus("iD", o, 6'h00, 1'b0, 1'b0, C_DEC, ret);
        applyStimulus("iEX", o, 6'h00, 1'b0, 1'b0, ex, ret);
        applyStimulus("iWB", o, 6'h00, 1'b0, 1'b0, C_IWB, ret);
    endtask

    task automatic doBranch(input logic [5:0] o, input logic z, input ctrl_t ex, input logic [3:0] ret);
        applyStimulus("bF", o, 6'h00, z, 1'b1, C_FR, ret);
        applyStimulus("bD", o, 6'h00, z, 1'b0, C_DEC, ret);
        applyStimulus("bEX", o, 6'h00, z, 1'b0, ex, ret);
    endtask

    task automatic doJump(input logic [5:0] o, input ctrl_t ex, input logic [3:0] ret);
        applyStimulus("jF", o, 6'h00, 1'b0, 1'b1, C_FR, ret);
        applyStimulus("jD", o, 6'h00, 1'b0, 1'b0, C_DEC, ret);
        applyStimulus("jEX", o, 6'h00, 1'b0, 1'b0, ex, ret);
    endtask

    task automatic doIllegal(input logic [5:0] o, input logic [5:0] f, input logic [3:0] ret);
        applyStimulus("illF", o, f, 1'b0, 1'b1, C_FR, ret);
        applyStimulus("illD", o, f, 1'b0, 1'b0, C_DEC_ILL, ret);
    endtask

    // Directed sequence; retired values are the running count of completed instructions.
    initial begin
        reset    = 1'b1;
        op       = 6'h00;
        funct    = 6'h00;
        zero     = 1'b0;
        memReady = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus("reset", RT, 6'h00, 1'b0, 1'b1, C_FW, 4'd0);
        reset = 1'b0;

        // LW: 2 fetch waits, 3 memrd waits, 10 cycles total.
        applyStimulus("lwFw1", LW, 6'h00, 1'b0, 1'b0, C_FW, 4'd0);
        applyStimulus("lwFw2", LW, 6'h00, 1'b0, 1'b0, C_FW, 4'd0);
        applyStimulus("lwF", LW, 6'h00, 1'b0, 1'b1, C_FR, 4'd0);
        applyStimulus("lwD", LW, 6'h00, 1'b0, 1'b1, C_DEC, 4'd0);
        applyStimulus("lwMA", LW, 6'h00, 1'b0, 1'b1, C_MADR, 4'd0);
        for (int i = 0; i < 3; i++)
            applyStimulus("lwMRw", LW, 6'h00, 1'b0, 1'b0, C_MRD, 4'd0);
        applyStimulus("lwMR", LW, 6'h00, 1'b0, 1'b1, C_MRD, 4'd0);
        applyStimulus("lwWB", LW, 6'h00, 1'b0, 1'b0, C_MWB, 4'd0);

        // SW with one write wait.
        applyStimulus("swF", SW, 6'h00, 1'b0, 1'b1, C_FR, 4'd1);
        applyStimulus("swD", SW, 6'h00, 1'b0, 1'b0, C_DEC, 4'd1);
        applyStimulus("swMA", SW, 6'h00, 1'b0, 1'b0, C_MADR, 4'd1);
        applyStimulus("swMWw", SW, 6'h00, 1'b0, 1'b0, C_MWR, 4'd1);
        applyStimulus("swMW", SW, 6'h00, 1'b0, 1'b1, C_MWR, 4'd1);

        doRtype(6'h20, C_REX_ADD, 4'd2);
        doRtype(6'h2A, C_REX_SLT, 4'd3);
        doBranch(BNE, 1'b0, C_BR_T, 4'd4);
        doBranch(BNE, 1'b1, C_BR_N, 4'd5);
        doBranch(BEQ, 1'b1, C_BR_T, 4'd6);
        doImm(ORI, C_IEX_OR, 4'd7);
        doImm(ANDI, C_IEX_AND, 4'd8);
        doImm(SLTI, C_IEX_SLT, 4'd9);
        doJump(JAL, C_JAL, 4'd10);
        doJump(J, C_JEX, 4'd11);
        doImm(ADDI, C_IEX_ADD, 4'd12);
        doIllegal(RT, 6'h27, 4'd13);
        doIllegal(6'h3F, 6'h00, 4'd13);
        doJump(J, C_JEX, 4'd13);
        doRtype(6'h22, C_REX_SUB, 4'd14);
        doIllegal(RT, 6'h27, 4'd15);
        doJump(J, C_JEX, 4'd15);
        doJump(J, C_JEX, 4'd0);

        // Reset arriving mid-MEMWR must kill memwrite immediately and clear retired.
        applyStimulus("sw2F", SW, 6'h00, 1'b0, 1'b1, C_FR, 4'd1);
        applyStimulus("sw2D", SW, 6'h00, 1'b0, 1'b0, C_DEC, 4'd1);
        applyStimulus("sw2MA", SW, 6'h00, 1'b0, 1'b0, C_MADR, 4'd1);
        applyStimulus("sw2MWw", SW, 6'h00, 1'b0, 1'b0, C_MWR, 4'd1);
        reset = 1'b1;
        applyStimulus("rstMemwr", SW, 6'h00, 1'b0, 1'b0, C_FW, 4'd0);
        reset = 1'b0;
        applyStimulus("postRstF", SW, 6'h00, 1'b0, 1'b1, C_FR, 4'd0);
        applyStimulus("postRstD", SW, 6'h00, 1'b0, 1'b0, C_DEC, 4'd0);

        // JAL on both instances: legal on A, illegal on B with no retire.
        reset = 1'b1;
        stepCore("rstAB", JAL, 6'h00, 1'b0, 1'b1, C_FW, 4'd0, 1'b1, C_FW, 32'd0);
        reset = 1'b0;
        stepCore("jalF", JAL, 6'h00, 1'b0, 1'b1, C_FR, 4'd0, 1'b1, C_FR, 32'd0);
        stepCore("jalD", JAL, 6'h00, 1'b0, 1'b1, C_DEC, 4'd0, 1'b1, C_DEC_ILL, 32'd0);
        stepCore("jalEX", JAL, 6'h00, 1'b0, 1'b1, C_JAL, 4'd0, 1'b1, C_FR, 32'd0);
        stepCore("jalNext", JAL, 6'h00, 1'b0, 1'b1, C_FR, 4'd1, 1'b1, C_DEC_ILL, 32'd0);

        @(negedge clk);
        #1;
        checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Safety net so the run always terminates.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/mc_ctrl_ext.md
# mc_ctrl_ext

Parametrised multicycle MIPS control unit: a Moore FSM with op/funct decode that drives the multicycle datapath (PC, IR, register file, ALU, unified memory). It extends the base controller in three ways. It adds optional memory wait states through a `mem_ready` handshake, and optional extended opcodes (ANDI, ORI, SLTI, BNE, JAL). It also adds internal PC-enable generation, illegal-instruction flagging and a retired-instruction counter. It sits between the instruction register and all datapath enables.

## Interface
- `MEM_WAIT`, default 1: 1 = honour `mem_ready` in FETCH/MEMRD/MEMWR; 0 = `mem_ready` ignored (treated as 1).
- `EXT_OPS`, default 1: 1 = ANDI/ORI/SLTI/BNE/JAL legal; 0 = those opcodes are illegal.
- `CNT_W`, default 32: width of `retired`.
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high.
- `op`  in  6  IR[31:26].
- `funct`  in  6  IR[5:0].
- `zero`  in  1  ALU zero flag.
- `mem_ready`  in  1  memory access completes this cycle.
- `pcen`  out  1  PC register load enable (jump/fetch OR taken branch).
- `irwrite`, `memwrite`, `regwrite`  out  1 each  datapath write enables.
- `iord`  out  1  0 = PC addresses memory, 1 = ALUOut.
- `alusrca`  out  1  0 = PC, 1 = A.
- `alusrcb`  out  2  00 = B, 01 = 4, 10 = immext, 11 = signimm<<2.
- `zeroext`  out  1  1 = zero-extend imm (ANDI/ORI), 0 = sign-extend.
- `regdst`  out  2  00 = rt, 01 = rd, 10 = r31.
- `memtoreg`  out  2  00 = ALUOut, 01 = mem data, 10 = PC.
- `pcsrc`  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- `alucontrol`  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt.
- `illegal`  out  1  one-cycle pulse: unsupported op/funct decoded.
- `retired`  out  `CNT_W`  count of completed instructions.

## Operation
- States (4-bit): FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTYPEEX 6, RTYPEWB 7, BREX 8, IMMEX 9, IMMWB 10, JEX 11, JALEX 12. Codes 13–15 go to FETCH next cycle with all enables 0.
- FETCH:
  - `iord`=0, `alusrca`=0, `alusrcb`=01, add, `pcsrc`=00.
  - `irwrite`=`pcen`=`rdy`, where `rdy` = `mem_ready` or !MEM_WAIT.
  - Stay in FETCH while !`rdy`; otherwise go to DECODE.
- DECODE:
  - `alusrca`=0, `alusrcb`=11, add.
  - LW/SW go to MEMADR. R-type with legal funct (20, 22, 24, 25, 2A hex) goes to RTYPEEX. BEQ/BNE go to BREX. ADDI/ANDI/ORI/SLTI go to IMMEX. J goes to JEX. JAL goes to JALEX.
  - Any other op or funct: `illegal`=1 and go to FETCH (PC already advanced, so the instruction acts as a NOP that is not retired).
- MEMADR: `alusrca`=1, `alusrcb`=10, `zeroext`=0, add. LW goes to MEMRD; SW goes to MEMWR.
- MEMRD: `iord`=1. Stay while !`rdy`, else go to MEMWB.
- MEMWB: `regwrite`=1, `regdst`=00, `memtoreg`=01.
- MEMWR:
  - `iord`=1 and `memwrite`=1, held until `rdy`.
  - Go to FETCH on the `rdy` cycle; data must not change while held.
- RTYPEEX: `alusrca`=1, `alusrcb`=00, `alucontrol` from funct. RTYPEWB: `regwrite`=1, `regdst`=01, `memtoreg`=00.
- BREX:
  - `alusrca`=1, `alusrcb`=00, sub, `pcsrc`=01.
  - `pcen` = `zero` for BEQ, !`zero` for BNE.
- IMMEX:
  - `alusrca`=1, `alusrcb`=10.
  - ADDI: add, `zeroext`=0. ANDI: and, `zeroext`=1. ORI: or, `zeroext`=1. SLTI: slt, `zeroext`=0.
- IMMWB: `regwrite`=1, `regdst`=00, `memtoreg`=00.
- JEX: `pcsrc`=10, `pcen`=1.
- JALEX: `pcsrc`=10, `pcen`=1, `regwrite`=1, `regdst`=10, `memtoreg`=10 (PC = old PC+4 is written to r31).
- Any output not listed for a state is 0; `alucontrol` defaults to add.
- `retired` increments by 1 (wrapping modulo 2^`CNT_W`) on every transition into FETCH from MEMWB, MEMWR, RTYPEWB, BREX, IMMWB, JEX or JALEX.

## Timing
- Reset asserted:
  - State goes to FETCH immediately; `retired` goes to 0.
  - `pcen`, `irwrite`, `memwrite`, `regwrite` and `illegal` are forced to 0 combinationally while `reset` is high.
  - Other outputs show FETCH values.
- Reset mid-instruction abandons it without retiring.
- First FETCH completes on the first `rdy` edge after reset deasserts.
- Outputs are Moore, except: `pcen`/`irwrite` in FETCH (follow `mem_ready`), `pcen` in BREX (follows `zero`), and `illegal` (follows `op`/`funct` in DECODE).
- Cycles per instruction with zero wait: LW 5, SW 4, R 4, ADDI/ANDI/ORI/SLTI 4, BEQ/BNE 3, J 3, JAL 3. Each wait cycle in FETCH/MEMRD/MEMWR adds 1.
- `mem_ready` outside FETCH/MEMRD/MEMWR is ignored.
- With EXT_OPS=0, ANDI/ORI/SLTI/BNE/JAL take the illegal path from DECODE.

## Test plan
- Reset high mid-MEMWR, `memwrite`=1 → `memwrite` drops the same cycle, state is FETCH, `retired`=0.
- MEM_WAIT=1, LW with `mem_ready` low for 2 cycles in FETCH and 3 in MEMRD → `irwrite` pulses only on the ready cycle; 10 cycles total; `regwrite`/`memtoreg`=01 in last cycle; `retired` +1.
- BNE with `zero`=0 → `pcen`=1 and `pcsrc`=01 in BREX; with `zero`=1 → `pcen`=0; both retire after 3 cycles.
- ORI → IMMEX drives `zeroext`=1 and `alucontrol`=001; IMMWB drives `regwrite`=1, `regdst`=00.
- JAL → JALEX drives `pcen`, `regwrite`, `regdst`=10, `memtoreg`=10, `pcsrc`=10 in one cycle; EXT_OPS=0 gives `illegal`=1 and `retired` unchanged.
- R-type funct=0x27 → `illegal` pulse in DECODE, no `regwrite`, back to FETCH; `retired`=2^`CNT_W`−1 then any retire → wraps to 0.
